// File: rtl/zigzag_pkg.sv
// rtl/zigzag_pkg.sv - zigzag table, coefficient types and helper for zigzag_buf
package zigzag_pkg;

    localparam int QW_DEFAULT = 15;

    typedef logic signed [QW_DEFAULT-1:0] coef_t;
    typedef logic [5:0] zz_idx_t;

    // Indexed by raster position; yields that coefficient's zigzag position.
    localparam zz_idx_t ZZ_TAB [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    function automatic zz_idx_t en_zigzag(input zz_idx_t raster);
        return ZZ_TAB[raster];
    endfunction

endpackage

// File: rtl/zigzag_lastnz.sv
// rtl/zigzag_lastnz.sv - per-block last non-zero position and all-zero tracker
module zigzag_lastnz
    import zigzag_pkg::*;
#(
    parameter int QW       = QW_DEFAULT,
    parameter int IN_LANES = 8,
    parameter int NBLK     = 2,
    localparam int PW      = $clog2(NBLK)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [IN_LANES-1:0][QW-1:0]  i_d,
    input  logic [IN_LANES-1:0][5:0]     i_addr,
    input  logic                         i_wr,
    input  logic                         i_first,
    input  logic [PW-1:0]                i_widx,
    input  logic [PW-1:0]                i_ridx,
    output logic [5:0]                   o_eob,
    output logic                         o_zero
);

    logic [5:0]      w_bmax;
    logic            w_bany;
    logic [5:0]      r_eob [NBLK];
    logic [NBLK-1:0] r_nz;

    always_comb begin
        w_bmax = '0;
        w_bany = 1'b0;
        for (int i = 0; i < IN_LANES; i++) begin
            if (i_d[i] != '0) begin
                w_bany = 1'b1;
                if (i_addr[i] > w_bmax) w_bmax = i_addr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NBLK; k++) r_eob[k] <= '0;
            r_nz <= '0;
        end else if (i_wr) begin
            // Beat 0 restarts the block's tracker; later beats merge into it.
            if (i_first) begin
                r_eob[i_widx] <= w_bmax;
                r_nz[i_widx]  <= w_bany;
            end else if (w_bany) begin
                if (w_bmax > r_eob[i_widx]) r_eob[i_widx] <= w_bmax;
                r_nz[i_widx] <= 1'b1;
            end
        end
    end

    assign o_eob  = r_eob[i_ridx];
    assign o_zero = ~r_nz[i_ridx];

endmodule

// File: rtl/zigzag_buf.sv
// rtl/zigzag_buf.sv - JPEG 8x8 coefficient raster-to-zigzag reorder buffer
// Optional last-non-zero tracker enabled by defining ZIGZAG_LASTNZ_EN.
module zigzag_buf
    import zigzag_pkg::*;
#(
    parameter int QW        = QW_DEFAULT,
    parameter int IN_LANES  = 8,
    parameter int OUT_LANES = 2,
    parameter int NBLK      = 2,
    localparam int IW       = (IN_LANES >= 64) ? 1 : $clog2(64 / IN_LANES),
    localparam int OW       = (OUT_LANES >= 64) ? 1 : $clog2(64 / OUT_LANES)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [IN_LANES-1:0][QW-1:0]   d,
    input  logic [IW-1:0]                 d_cnt,
    input  logic                          d_zz,
    input  logic                          d_valid,
    output logic                          d_hold,
    output logic [OUT_LANES-1:0][QW-1:0]  q,
    output logic [OW-1:0]                 q_cnt,
    output logic                          q_last,
    output logic [5:0]                    q_eob,
    output logic                          q_zero,
    output logic                          q_valid,
    input  logic                          q_hold,
    output logic                          err
);

    localparam int PW     = $clog2(NBLK);
    localparam int IBEATS = 64 / IN_LANES;
    localparam int OBEATS = 64 / OUT_LANES;

    logic [QW-1:0]                 r_mem [NBLK*64];
    logic [PW:0]                   r_wptr, r_rptr;
    logic [IW-1:0]                 r_wcnt;
    logic [OW-1:0]                 r_rcnt;
    logic                          r_wzz, r_err;
    logic [OUT_LANES-1:0][QW-1:0]  r_q;
    logic [OW-1:0]                 r_qcnt;
    logic                          r_qlast, r_qvalid;

    logic                          w_full, w_empty, w_wr, w_load;
    logic                          w_wlast, w_rlast, w_zz;
    logic [IN_LANES-1:0][5:0]      w_addr;

    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_wr    = d_valid & ~w_full;
    assign w_load  = ~w_empty & (~r_qvalid | ~q_hold);
    assign w_wlast = (r_wcnt == IW'(IBEATS - 1));
    assign w_rlast = (r_rcnt == OW'(OBEATS - 1));
    // Mode is taken live on beat 0 and held for the remaining beats of the block.
    assign w_zz    = (r_wcnt == '0) ? d_zz : r_wzz;

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            w_addr[i] = w_zz ? en_zigzag(6'(int'(r_wcnt) * IN_LANES + i))
                             : 6'(int'(r_wcnt) * IN_LANES + i);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < IN_LANES; i++)
                r_mem[{r_wptr[PW-1:0], w_addr[i]}] <= d[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_wcnt <= '0;
            r_wzz  <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_wr) begin
            r_wzz <= w_zz;
            if (d_cnt != r_wcnt) r_err <= 1'b1;
            if (w_wlast) begin
                r_wcnt <= '0;
                r_wptr <= r_wptr + 1'b1;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    // A block slot is released as soon as its final beat is captured in r_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rptr   <= '0;
            r_rcnt   <= '0;
            r_q      <= '0;
            r_qcnt   <= '0;
            r_qlast  <= 1'b0;
            r_qvalid <= 1'b0;
        end else if (w_load) begin
            for (int j = 0; j < OUT_LANES; j++)
                r_q[j] <= r_mem[{r_rptr[PW-1:0], 6'(int'(r_rcnt) * OUT_LANES + j)}];
            r_qcnt   <= r_rcnt;
            r_qlast  <= w_rlast;
            r_qvalid <= 1'b1;
            if (w_rlast) begin
                r_rcnt <= '0;
                r_rptr <= r_rptr + 1'b1;
            end else begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end else if (~q_hold) begin
            r_qvalid <= 1'b0;
        end
    end

`ifdef ZIGZAG_LASTNZ_EN
    logic [5:0] w_eob, r_qeob;
    logic       w_zero, r_qzero;

    zigzag_lastnz #(
        .QW       (QW),
        .IN_LANES (IN_LANES),
        .NBLK     (NBLK)
    ) u_lastnz (
        .clk     (clk),
        .resetn  (resetn),
        .i_d     (d),
        .i_addr  (w_addr),
        .i_wr    (w_wr),
        .i_first (r_wcnt == '0),
        .i_widx  (r_wptr[PW-1:0]),
        .i_ridx  (r_rptr[PW-1:0]),
        .o_eob   (w_eob),
        .o_zero  (w_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_qeob  <= '0;
            r_qzero <= 1'b1;
        end else if (w_load) begin
            r_qeob  <= w_eob;
            r_qzero <= w_zero;
        end
    end

    assign q_eob  = r_qeob;
    assign q_zero = r_qzero;
`else
    assign q_eob  = 6'd63;
    assign q_zero = 1'b0;
`endif

    assign d_hold  = w_full;
    assign q       = r_q;
    assign q_cnt   = r_qcnt;
    assign q_last  = r_qlast;
    assign q_valid = r_qvalid;
    assign err     = r_err;

endmodule

// File: tb/tb_zigzag_buf.sv
// tb/tb_zigzag_buf.sv - directed self-checking bench for zigzag_buf
module tb_zigzag_buf;

    logic             clk;
    logic             resetn;
    logic [7:0][14:0] d;
    logic [2:0]       d_cnt;
    logic             d_zz;
    logic             d_valid;
    logic             d_hold;
    logic [1:0][14:0] q;
    logic [4:0]       q_cnt;
    logic             q_last;
    logic [5:0]       q_eob;
    logic             q_zero;
    logic             q_valid;
    logic             q_hold;
    logic             err;

    int checks   = 0;
    int failures = 0;

`ifdef ZIGZAG_LASTNZ_EN
    localparam logic [5:0] RST_EOB  = 6'd0;
    localparam logic       RST_ZERO = 1'b1;
    localparam logic [5:0] SP_ZZ_EOB = 6'd4;
    localparam logic [5:0] SP_BY_EOB = 6'd9;
    localparam logic [5:0] Z_EOB     = 6'd0;
    localparam logic       Z_ZERO    = 1'b1;
`else
    localparam logic [5:0] RST_EOB  = 6'd63;
    localparam logic       RST_ZERO = 1'b0;
    localparam logic [5:0] SP_ZZ_EOB = 6'd63;
    localparam logic [5:0] SP_BY_EOB = 6'd63;
    localparam logic [5:0] Z_EOB     = 6'd63;
    localparam logic       Z_ZERO    = 1'b0;
`endif

    // Zigzag position -> raster position (standard JPEG scan order).
    int unzz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    zigzag_buf dut (
        .clk     (clk),
        .resetn  (resetn),
        .d       (d),
        .d_cnt   (d_cnt),
        .d_zz    (d_zz),
        .d_valid (d_valid),
        .d_hold  (d_hold),
        .q       (q),
        .q_cnt   (q_cnt),
        .q_last  (q_last),
        .q_eob   (q_eob),
        .q_zero  (q_zero),
        .q_valid (q_valid),
        .q_hold  (q_hold),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] gen(input int pat, input int r);
        case (pat)
            1:       return 15'(r + 1);
            2:       return 15'(r + 101);
            3:       return 15'(r + 201);
            4:       return (r == 0) ? 15'd7 : ((r == 9) ? 15'h7ffd : 15'd0);
            default: return 15'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_d_hold", d_hold, 0);
        chk("rst_q", q, 0);
        chk("rst_q_cnt", q_cnt, 0);
        chk("rst_q_last", q_last, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_q_eob", q_eob, RST_EOB);
        chk("rst_q_zero", q_zero, RST_ZERO);
    endtask

    task automatic send_beat(input int pat, input int b, input logic [2:0] cnt, input bit zz);
        int wait_n = 0;
        d_valid = 1'b1;
        d_cnt   = cnt;
        d_zz    = zz;
        for (int i = 0; i < 8; i++) d[i] = gen(pat, b * 8 + i);
        while (d_hold && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (d_hold) chk("d_hold_timeout", d_hold, 0);
        @(posedge clk); #1;
    endtask

    task automatic send_block(input int pat, input bit zz);
        for (int b = 0; b < 8; b++) send_beat(pat, b, 3'(b), zz);
        d_valid = 1'b0;
    endtask

    task automatic recv_block(input int pat, input bit zz, input logic [5:0] eob, input bit zero);
        int wait_n;
        int p;
        logic [14:0] e0, e1;
        q_hold = 1'b0;
        for (int b = 0; b < 32; b++) begin
            wait_n = 0;
            while (!q_valid && wait_n < 40) begin
                @(posedge clk); #1;
                wait_n++;
            end
            p  = 2 * b;
            e0 = gen(pat, zz ? unzz[p] : p);
            e1 = gen(pat, zz ? unzz[p+1] : p + 1);
            chk("q_beat", {q_valid, q_last, q_cnt, q[1], q[0], q_eob, q_zero},
                          {1'b1, (b == 31), 5'(b), e1, e0, eob, zero});
            @(posedge clk); #1;
        end
        q_hold = 1'b1;
    endtask

    initial begin
        clk     = 1'b0;
        resetn  = 1'b0;
        d       = '0;
        d_cnt   = '0;
        d_zz    = 1'b0;
        d_valid = 1'b0;
        q_hold  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single zigzag block, latency and ordering
        send_block(1, 1'b1);
        chk("lat_edge_e", q_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge_e1", q_valid, 1);
        recv_block(1, 1'b1, 6'd63, 1'b0);

        // Raster bypass
        send_block(1, 1'b0);
        recv_block(1, 1'b0, 6'd63, 1'b0);

        // Back-pressure: fill both slots, check hold and stable output
        send_block(1, 1'b1);
        chk("hold_after_b1", d_hold, 0);
        send_block(2, 1'b1);
        chk("hold_after_b2", d_hold, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("held_q", {q_valid, q_cnt, q[1], q[0]}, {1'b1, 5'd0, 15'd2, 15'd1});
        recv_block(1, 1'b1, 6'd63, 1'b0);
        chk("hold_freed", d_hold, 0);
        send_block(3, 1'b1);
        recv_block(2, 1'b1, 6'd63, 1'b0);
        recv_block(3, 1'b1, 6'd63, 1'b0);

        // Last non-zero tracking
        send_block(4, 1'b1);
        recv_block(4, 1'b1, SP_ZZ_EOB, 1'b0);
        send_block(4, 1'b0);
        recv_block(4, 1'b0, SP_BY_EOB, 1'b0);
        send_block(0, 1'b1);
        recv_block(0, 1'b1, Z_EOB, Z_ZERO);

        // Sequence error
        send_beat(1, 0, 3'd0, 1'b1);
        send_beat(1, 1, 3'd1, 1'b1);
        chk("err_before", err, 0);
        send_beat(1, 2, 3'd3, 1'b1);
        chk("err_set", err, 1);
        for (int b = 3; b < 8; b++) send_beat(1, b, 3'(b + 1), 1'b1);
        d_valid = 1'b0;
        recv_block(1, 1'b1, 6'd63, 1'b0);
        chk("err_sticky", err, 1);

        // Reset mid-block, then a clean block
        for (int b = 0; b < 3; b++) send_beat(2, b, 3'(b), 1'b1);
        d_valid = 1'b0;
        resetn  = 1'b0;
        #1;
        chk_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        send_block(3, 1'b1);
        recv_block(3, 1'b1, 6'd63, 1'b0);
        chk("err_after_rst", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zigzag_buf.md
# zigzag_buf

Parametrised JPEG coefficient reorder buffer: accepts 8x8 quantised blocks in raster order, `IN_LANES` coefficients per beat, and emits them `OUT_LANES` per beat in zigzag (or raster-bypass) order. It holds `NBLK` blocks so input and output overlap. It sits between quantiser and entropy coder, runs on one clock, and optionally reports each block's last non-zero zigzag index for early end-of-block.

## Interface
Parameters:
- `QW`, 15, coefficient width (signed).
- `IN_LANES`, 8, coefficients per input beat; power of 2, 1..64.
- `OUT_LANES`, 2, coefficients per output beat; power of 2, 1..64.
- `NBLK`, 2, block buffers; power of 2, >= 2.

Ports:
- `clk` in 1: clock. Single clock; reset is asynchronous and active-low.
- `resetn` in 1: asynchronous active-low reset.
- `d` in `IN_LANES`x`QW`: raster coefficients; lane i is raster index `d_cnt*IN_LANES+i`.
- `d_cnt` in log2(64/IN_LANES): beat index within block.
- `d_zz` in 1: 1 = zigzag, 0 = raster bypass; sampled on beat 0, applies to whole block.
- `d_valid` in 1, `d_hold` out 1: input handshake; transfer when `d_valid & ~d_hold`.
- `q` out `OUT_LANES`x`QW`: output coefficients, lane j = output position `q_cnt*OUT_LANES+j`.
- `q_cnt` out log2(64/OUT_LANES): output beat index.
- `q_last` out 1: final beat of block.
- `q_eob` out 6: last non-zero zigzag position of current block (stable across all beats of block).
- `q_zero` out 1: block entirely zero.
- `q_valid` out 1, `q_hold` in 1: output handshake; transfer when `q_valid & ~q_hold`.
- `err` out 1: sticky sequence error.

## Operation
- Storage: `NBLK`x64 entries of `QW`, flop array; write pointer `wptr`, read pointer `rptr`, each log2(NBLK)+1 bits (wrap bit).
- Full = pointers differ only in MSB; empty = equal. `d_hold = full`.
- Write: internal beat counter `wcnt` is authoritative. Each lane writes to address `ZZ[raster]` (zigzag mode) or `raster` (bypass). On the beat with `wcnt` = max, `wptr` increments and `wcnt` wraps to 0.
- `d_cnt != wcnt` on an accepted beat sets `err` (cleared only by reset); data written per `wcnt` regardless.
- Per-block mode bit and eob/zero registers are stored alongside each block buffer.
- Read: `rcnt` steps on each output transfer; on last beat `rptr` increments.
- Output register loads when `~empty & (~q_valid | ~q_hold)`; `q_valid` drops when register drains and buffer empty.
- Simultaneous block completion (write) and block release (read): both pointers move; occupancy unchanged. Write into a block being read is impossible (full guard).
- Reset mid-block: all partial/complete blocks discarded, counters and pointers to 0.
- Reset values: `d_hold` 0, `q` 0, `q_cnt` 0, `q_last` 0, `q_eob` 0, `q_zero` 1, `q_valid` 0, `err` 0.

## Timing
- Beat accepted at edge E that completes a block: block readable after E; `q_valid` high after edge E+1 (2-edge latency, first output beat cycle after completion).
- Throughput: one input beat and one output beat per cycle, no bubbles when `q_hold` low and buffer neither full nor empty.
- `q_hold` high: `q*` held stable; no pointer/count movement.
- `d_hold` depends only on registered state (no combinational path from `q_hold`).

## Configuration
- `ZIGZAG_LASTNZ_EN` defined: during write, max zigzag position of non-zero lanes is merged into the block's eob register (cleared on beat 0); `q_eob`/`q_zero` valid per block. In bypass mode eob is the max raster position.
- Undefined: tracker not built; `q_eob` tied to 63, `q_zero` tied to 0; ports retained.

## Structure
- `zigzag_pkg`: 64-entry zigzag table constant, `en_zigzag` function, coefficient typedef.
- Sub-module `zigzag_lastnz`: per-beat max-index reduction over `IN_LANES` plus per-block eob/zero registers; instantiated only under `ZIGZAG_LASTNZ_EN`.

## Test plan
- Single block, defaults, `d[raster]=raster+1`, zigzag: output beats give 1,2,9,17,10,3,...,64; `q_last` on beat 31; `q_valid` two edges after final input beat.
- Same block with `d_zz=0`: output 1..64 in order.
- Three back-to-back blocks, `q_hold` held high: `d_hold` rises after block 2 completes; release -> blocks stream in order, no loss.
- `d_cnt` sequence 0,1,3,...: `err` set after third beat, stays set until reset.
- `ZIGZAG_LASTNZ_EN`: only raster 0 and raster 9 (zigzag 4) non-zero -> `q_eob`=4, `q_zero`=0; all-zero block -> `q_zero`=1.
- Assert `resetn` low after 3 of 8 input beats: all outputs to reset values; next full block emerges correctly with no stale data.
